vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receiving end of the VGA pixel interface: samples the pixel stream produced by the graphics/VGA controller (syncs, blank, 24-bit colour, pixel strobe).
- Recovers active-pixel coordinates and measures line/frame timing against parameters.
- Reports lock status, timing errors, and a per-frame pixel checksum.
- Used as a self-check block in the top level and as the primary checker in graphics testbenches.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- H_TOTAL, 800, total pixel strobes per line (hsync fall to hsync fall).
- V_ACTIVE, 480, active lines per frame.
- V_TOTAL, 525, total lines per frame (vsync fall to vsync fall).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel strobe; all inputs below are sampled only on clk edges with pix_en=1.
- hsync_n  in  1  horizontal sync, active low.
- vsync_n  in  1  vertical sync, active low.
- blank_n  in  1  1 = active video pixel.
- pix_data  in  24  {r,g,b}, 8 bits each.
- rx_valid  out  1  one-cycle pulse: active pixel captured.
- rx_x  out  10  column of captured pixel.
- rx_y  out  10  row of captured pixel.
- rx_data  out  24  captured pixel colour.
- locked  out  1  timing matches parameters.
- line_err  out  1  one-cycle pulse: bad line period or active width.
- frame_err  out  1  one-cycle pulse: bad frame line count or active line count.
- frame_done  out  1  one-cycle pulse at frame boundary.
- frame_sum  out  16  checksum of the last completed frame.
- h_meas  out  10  last measured line period in strobes.
- v_meas  out  10  last measured frame period in lines.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM in SEARCH; counters, edge registers and accumulator cleared. Edge registers reset to 1 (deasserted).
- Edge detection: hfall = sampled hsync_n=0 with previous sampled value 1; vfall is defined the same way on vsync_n. Previous values update only on pix_en samples.
- Line counting:
  - h_cnt is set to 1 on an hfall sample and increments on every other sample.
  - Saturates at 1023.
- Line checks, on hfall when at least one prior hfall has been seen:
  - h_meas <= h_cnt.
  - line_err pulses if h_cnt != H_TOTAL, or if the finished line had nonzero active pixels and that count != H_ACTIVE.
  - line_err is suppressed in SEARCH.
- Frame counting:
  - v_cnt counts hfalls since the last vfall and saturates at 1023.
  - act_lines counts finished lines that had at least 1 active pixel.
  - An hfall and a vfall in the same sample close the line first, then the frame.
- Frame checks, on vfall when a prior vfall has been seen:
  - v_meas <= v_cnt.
  - frame_err pulses if v_cnt != V_TOTAL or act_lines != V_ACTIVE.
  - frame_done pulses in SYNC and LOCKED.
  - frame_sum <= accumulator; the accumulator then clears.
- Coordinates:
  - rx_x is the active-pixel index within the line and clears on hfall.
  - rx_y is act_lines and clears on vfall.
  - An active sample (pix_en & blank_n) produces rx_valid=1 on the next clk with rx_x, rx_y, rx_data for that pixel. The x counter then increments, wrapping at 1023.
  - rx_* hold their values when rx_valid=0.
- Checksum: accumulator += r+g+b (zero-extended, mod 2^16) per active sample.
- FSM states:
  - SEARCH: locked=0. First vfall -> SYNC.
  - SYNC: locked=0. Next vfall with no line_err/frame_err during the frame -> LOCKED; with an error -> stay in SYNC and restart the frame check.
  - LOCKED: locked=1. Any line_err or frame_err -> SEARCH, and locked drops the following cycle.
- Latency: all outputs are registered, 1 clk after the causing sample.
- Mid-frame reset: return to SEARCH; the next frame is not trusted until two vfalls have been seen.

Test Plan:
All scenarios use H_ACTIVE=8, H_TOTAL=12, V_ACTIVE=4, V_TOTAL=6, pix_en every 2nd clk.
1. Three ideal frames, pix_data=0x010203 constant -> locked rises after the 2nd vfall; frame_sum=0x00C0 (32 pixels x 6); h_meas=12, v_meas=6; no err pulses.
2. Ideal frame with pix_data = {x,y,0} -> rx_valid pulses 32 times per frame, each 1 clk after its sample; rx_x 0..7, rx_y 0..3; rx_data matches the sampled pixel.
3. While locked, one line of 13 strobes -> line_err pulse, h_meas=13, locked=0 next clk, FSM in SEARCH; relock after two more clean frames.
4. Frame with 7 lines -> frame_err pulse at vfall, v_meas=7; when already in SYNC, no lock that frame.
5. Line with blank_n active for only 7 pixels -> line_err.
6. hsync held high for 1100 strobes -> h_cnt saturates at 1023; line_err on the next hfall; rst pulse mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers active-pixel coordinates, measures
// line/frame periods, tracks lock and accumulates a per-frame colour checksum.
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync_n,
  input  logic        vsync_n,
  input  logic        blank_n,
  input  logic [23:0] pix_data,
  output logic        rx_valid,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [23:0] rx_data,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas
);

  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] HTotal  = 10'(H_TOTAL);
  localparam logic [9:0] VActive = 10'(V_ACTIVE);
  localparam logic [9:0] VTotal  = 10'(V_TOTAL);
  localparam logic [9:0] CntMax  = 10'h3ff;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_err_seen;
  logic        w_err_seen_d;

  logic        r_hs_prev;
  logic        r_vs_prev;
  logic        r_h_seen;
  logic        r_v_seen;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_x_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  r_act_lines;
  logic [15:0] r_acc;

  logic        w_hfall;
  logic        w_vfall;
  logic        w_active;
  logic        w_line_had_px;
  logic        w_line_chk;
  logic        w_line_bad;
  logic        w_line_err;
  logic        w_frame_chk;
  logic        w_frame_err;
  logic [9:0]  w_v_line;
  logic [9:0]  w_al_line;
  logic [9:0]  w_x_cur;
  logic [9:0]  w_y_cur;
  logic [15:0] w_pix_sum;

  assign w_hfall       = pix_en & ~hsync_n & r_hs_prev;
  assign w_vfall       = pix_en & ~vsync_n & r_vs_prev;
  assign w_active      = pix_en & blank_n;
  assign w_line_had_px = (r_x_cnt != 10'd0);
  assign w_line_chk    = w_hfall & r_h_seen;
  assign w_line_bad    = (r_h_cnt != HTotal) | (w_line_had_px & (r_x_cnt != HActive));
  assign w_line_err    = w_line_chk & w_line_bad & (r_state != StSearch);
  assign w_pix_sum     = {8'h00, pix_data[23:16]} + {8'h00, pix_data[15:8]}
                       + {8'h00, pix_data[7:0]};

  // Line closes before frame when hfall and vfall share a sample, so the frame
  // check sees the counts including the line that just finished.
  always_comb begin
    w_v_line  = r_v_cnt;
    w_al_line = r_act_lines;
    if (w_hfall && (r_v_cnt != CntMax)) begin
      w_v_line = r_v_cnt + 10'd1;
    end
    if (w_hfall && w_line_had_px && (r_act_lines != CntMax)) begin
      w_al_line = r_act_lines + 10'd1;
    end
  end

  assign w_frame_chk = w_vfall & r_v_seen;
  assign w_frame_err = w_frame_chk & ((w_v_line != VTotal) | (w_al_line != VActive));
  assign w_x_cur     = w_hfall ? 10'd0 : r_x_cnt;
  assign w_y_cur     = w_vfall ? 10'd0 : w_al_line;

  always_comb begin
    w_state_d    = r_state;
    w_err_seen_d = r_err_seen;
    unique case (r_state)
      StSearch: begin
        if (w_vfall) begin
          w_state_d    = StSync;
          w_err_seen_d = 1'b0;
        end
      end
      StSync: begin
        if (w_vfall) begin
          if (r_err_seen || w_line_err || w_frame_err) begin
            w_err_seen_d = 1'b0;
          end else begin
            w_state_d = StLocked;
          end
        end else if (w_line_err || w_frame_err) begin
          w_err_seen_d = 1'b1;
        end
      end
      StLocked: begin
        if (w_line_err || w_frame_err) begin
          w_state_d = StSearch;
        end
      end
      default: w_state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StSearch;
      r_err_seen <= 1'b0;
      locked     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_err_seen <= w_err_seen_d;
      locked     <= (w_state_d == StLocked);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_prev   <= 1'b1;
      r_vs_prev   <= 1'b1;
      r_h_seen    <= 1'b0;
      r_v_seen    <= 1'b0;
      r_h_cnt     <= '0;
      r_x_cnt     <= '0;
      r_v_cnt     <= '0;
      r_act_lines <= '0;
      r_acc       <= '0;
      rx_valid    <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_data     <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
    end else begin
      rx_valid    <= w_active;
      line_err    <= w_line_err;
      frame_err   <= w_frame_err;
      frame_done  <= w_frame_chk & (r_state != StSearch);
      r_v_cnt     <= w_vfall ? 10'd0 : w_v_line;
      r_act_lines <= w_y_cur;

      if (pix_en) begin
        r_hs_prev <= hsync_n;
        r_vs_prev <= vsync_n;
        if (w_hfall) begin
          r_h_cnt <= 10'd1;
        end else if (r_h_cnt != CntMax) begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end

      if (w_hfall) begin
        r_h_seen <= 1'b1;
      end
      if (w_vfall) begin
        r_v_seen <= 1'b1;
      end
      if (w_line_chk) begin
        h_meas <= r_h_cnt;
      end
      if (w_frame_chk) begin
        v_meas    <= w_v_line;
        frame_sum <= r_acc;
      end

      if (w_active) begin
        rx_x    <= w_x_cur;
        rx_y    <= w_y_cur;
        rx_data <= pix_data;
        r_x_cnt <= w_x_cur + 10'd1;
      end else if (w_hfall) begin
        r_x_cnt <= 10'd0;
      end

      // A pixel sampled on the vfall belongs to the new frame's checksum.
      if (w_vfall) begin
        r_acc <= w_active ? w_pix_sum : 16'd0;
      end else if (w_active) begin
        r_acc <= r_acc + w_pix_sum;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Self-checking bench for vga_sync_monitor: reset and table vectors, directed
// timing scenarios and randomised frames checked against an event-level model.
module tb_vga_sync_monitor;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 4;
  localparam int VT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic        hsync_n = 1'b1;
  logic        vsync_n = 1'b1;
  logic        blank_n = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        rx_valid;
  logic [9:0]  rx_x;
  logic [9:0]  rx_y;
  logic [23:0] rx_data;
  logic        locked;
  logic        line_err;
  logic        frame_err;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [9:0]  h_meas;
  logic [9:0]  v_meas;

  vga_sync_monitor #(
    .H_ACTIVE(HA),
    .H_TOTAL (HT),
    .V_ACTIVE(VA),
    .V_TOTAL (VT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .blank_n   (blank_n),
    .pix_data  (pix_data),
    .rx_valid  (rx_valid),
    .rx_x      (rx_x),
    .rx_y      (rx_y),
    .rx_data   (rx_data),
    .locked    (locked),
    .line_err  (line_err),
    .frame_err (frame_err),
    .frame_done(frame_done),
    .frame_sum (frame_sum),
    .h_meas    (h_meas),
    .v_meas    (v_meas)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: event-level view of the stream (strobe indices of the
  // last syncs, pixel/line tallies) and the expected output values.
  int m_n, m_last_hf, m_last_vf, m_line_px, m_hfv, m_lpx, m_acc, m_mode;
  bit m_prev_hs, m_prev_vs, m_dirty, m_vf;
  int e_valid, e_x, e_y, e_data, e_lerr, e_ferr, e_done, e_sum, e_hmeas, e_vmeas, e_locked;

  // Scenario observations
  int n_valid, n_lerr, n_ferr, cap_hmeas, cap_vmeas, cap_locked, vf_count, lock_vf;
  bit junk;

  typedef struct {
    bit          hs;
    bit          bl;
    logic [23:0] d;
    bit          ev;
    logic [9:0]  ex;
    logic [23:0] ed;
    logic [9:0]  eh;
    bit          el;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (strobe %0d, t=%0t)", name, act, exp,
               m_n, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_last_hf = -1; m_last_vf = -1; m_line_px = 0; m_hfv = 0; m_lpx = 0;
    m_acc = 0; m_mode = 0; m_prev_hs = 1'b1; m_prev_vs = 1'b1; m_dirty = 1'b0; m_vf = 1'b0;
    e_valid = 0; e_x = 0; e_y = 0; e_data = 0; e_lerr = 0; e_ferr = 0; e_done = 0;
    e_sum = 0; e_hmeas = 0; e_vmeas = 0; e_locked = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit bl, input logic [23:0] d);
    bit hf, vf, err;
    int period;
    hf = !hs && m_prev_hs;
    vf = !vs && m_prev_vs;
    e_valid = 0; e_lerr = 0; e_ferr = 0; e_done = 0;
    if (hf) begin
      if (m_last_hf >= 0) begin
        period = m_n - m_last_hf;
        if (period > 1023) period = 1023;
        e_hmeas = period;
        if ((period != HT || (m_line_px != 0 && m_line_px != HA)) && m_mode != 0) e_lerr = 1;
      end
      if (m_hfv < 1023) m_hfv++;
      if (m_line_px != 0 && m_lpx < 1023) m_lpx++;
      m_last_hf = m_n;
      m_line_px = 0;
    end
    if (vf) begin
      if (m_last_vf >= 0) begin
        e_vmeas = m_hfv;
        e_ferr  = (m_hfv != VT || m_lpx != VA) ? 1 : 0;
        e_done  = (m_mode != 0) ? 1 : 0;
        e_sum   = m_acc;
      end
      m_hfv = 0; m_lpx = 0; m_acc = 0; m_last_vf = m_n;
    end
    if (bl) begin
      e_valid = 1; e_x = m_line_px % 1024; e_y = m_lpx; e_data = int'(d);
      m_line_px++;
      m_acc = (m_acc + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0])) % 65536;
    end
    err = (e_lerr != 0) || (e_ferr != 0);
    case (m_mode)
      0: if (vf) begin m_mode = 1; m_dirty = 1'b0; end
      1: begin
        if (vf) begin
          if (m_dirty || err) m_dirty = 1'b0;
          else m_mode = 2;
        end else if (err) m_dirty = 1'b1;
      end
      default: if (err) m_mode = 0;
    endcase
    e_locked = (m_mode == 2) ? 1 : 0;
    m_prev_hs = hs; m_prev_vs = vs; m_vf = vf; m_n++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rx_valid"},   32'(rx_valid),   32'(e_valid));
    chk({tag, "_rx_x"},       32'(rx_x),       32'(e_x));
    chk({tag, "_rx_y"},       32'(rx_y),       32'(e_y));
    chk({tag, "_rx_data"},    32'(rx_data),    32'(e_data));
    chk({tag, "_locked"},     32'(locked),     32'(e_locked));
    chk({tag, "_line_err"},   32'(line_err),   32'(e_lerr));
    chk({tag, "_frame_err"},  32'(frame_err),  32'(e_ferr));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(e_done));
    chk({tag, "_frame_sum"},  32'(frame_sum),  32'(e_sum));
    chk({tag, "_h_meas"},     32'(h_meas),     32'(e_hmeas));
    chk({tag, "_v_meas"},     32'(v_meas),     32'(e_vmeas));
  endtask

  task automatic observe();
    if (rx_valid) n_valid++;
    if (line_err) begin n_lerr++; cap_hmeas = int'(h_meas); cap_locked = int'(locked); end
    if (frame_err) begin n_ferr++; cap_vmeas = int'(v_meas); end
  endtask

  task automatic clear_obs();
    n_valid = 0; n_lerr = 0; n_ferr = 0; cap_hmeas = -1; cap_vmeas = -1; cap_locked = -1;
    vf_count = 0; lock_vf = -1;
  endtask

  task automatic strobe_sample(input bit hs, input bit vs, input bit bl, input logic [23:0] d);
    hsync_n = hs; vsync_n = vs; blank_n = bl; pix_data = d; pix_en = 1'b1;
    @(posedge clk);
    #1;
    model_step(hs, vs, bl, d);
    check_all("strobe");
    observe();
    if (m_vf) vf_count++;
    if (locked && lock_vf < 0) lock_vf = vf_count;
  endtask

  task automatic idle_tail();
    int gap;
    pix_en = 1'b0;
    gap = 1;
    if (junk) begin
      hsync_n  = 1'($urandom_range(0, 1));
      vsync_n  = 1'($urandom_range(0, 1));
      blank_n  = 1'($urandom_range(0, 1));
      pix_data = 24'($urandom);
      gap      = $urandom_range(1, 2);
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
      e_valid = 0; e_lerr = 0; e_ferr = 0; e_done = 0;
      check_all("idle");
      observe();
    end
  endtask

  task automatic strobe(input bit hs, input bit vs, input bit bl, input logic [23:0] d);
    strobe_sample(hs, vs, bl, d);
    idle_tail();
  endtask

  task automatic send_line(input int len, input int nact, input bit vs, input int mode,
                           input int y);
    for (int s = 0; s < len; s++) begin
      bit          hs;
      bit          bl;
      logic [23:0] d;
      hs = (s >= 2);
      bl = (s >= 2) && (s < 2 + nact);
      case (mode)
        0:       d = 24'h010203;
        1:       d = {8'(s - 2), 8'(y), 8'h00};
        default: d = 24'($urandom);
      endcase
      strobe(hs, vs, bl, d);
    end
  endtask

  task automatic send_frame(input int nl, input int bad_l, input int bad_len,
                            input int bad_act, input int mode);
    for (int l = 0; l < nl; l++) begin
      int len;
      int nact;
      len  = HT;
      nact = (l >= 2 && l < 2 + VA) ? HA : 0;
      if (l == bad_l) begin
        len = bad_len;
        if (bad_act >= 0) nact = bad_act;
      end
      send_line(len, nact, (l >= 2), mode, l - 2);
    end
  endtask

  task automatic send_rand_frame();
    int nl;
    nl = VT;
    if ($urandom_range(0, 7) == 0) nl = ($urandom_range(0, 1) != 0) ? VT - 1 : VT + 1;
    for (int l = 0; l < nl; l++) begin
      int len;
      int nact;
      len  = HT;
      nact = (l >= 2 && l < 2 + VA) ? HA : 0;
      if ($urandom_range(0, 11) == 0) len = ($urandom_range(0, 1) != 0) ? HT - 1 : HT + 1;
      if (nact != 0 && $urandom_range(0, 11) == 0) nact = ($urandom_range(0, 1) != 0) ? 7 : 9;
      send_line(len, nact, (l >= 2), 2, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    junk = 1'b0;
    clear_obs();
    tbl[0] = '{1'b0, 1'b0, 24'h000000, 1'b0, 10'd0, 24'h000000, 10'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 24'ha1b2c3, 1'b1, 10'd0, 24'ha1b2c3, 10'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 24'h123456, 1'b1, 10'd1, 24'h123456, 10'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 24'hffffff, 1'b0, 10'd1, 24'h123456, 10'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 24'h000000, 1'b0, 10'd1, 24'h123456, 10'd4, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 24'h0f0f0f, 1'b1, 10'd0, 24'h0f0f0f, 10'd4, 1'b0};

    // Power-on reset
    model_reset();
    #3;
    check_all("por");
    @(negedge clk);
    rst = 1'b1;

    // Table vectors, still in search
    for (int i = 0; i < 6; i++) begin
      strobe_sample(tbl[i].hs, 1'b1, tbl[i].bl, tbl[i].d);
      chk($sformatf("tbl%0d_rx_valid", i), 32'(rx_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_rx_x", i),     32'(rx_x),     32'(tbl[i].ex));
      chk($sformatf("tbl%0d_rx_data", i),  32'(rx_data),  32'(tbl[i].ed));
      chk($sformatf("tbl%0d_h_meas", i),   32'(h_meas),   32'(tbl[i].eh));
      chk($sformatf("tbl%0d_line_err", i), 32'(line_err), 32'(tbl[i].el));
      idle_tail();
    end

    // Three ideal frames of constant colour
    do_reset();
    clear_obs();
    repeat (3) send_frame(VT, -1, 0, -1, 0);
    strobe(1'b0, 1'b0, 1'b0, 24'h0);
    chk("s1_lock_after_vfall", 32'(lock_vf), 32'd2);
    chk("s1_locked", 32'(locked), 32'd1);
    chk("s1_frame_sum", 32'(frame_sum), 32'h00c0);
    chk("s1_h_meas", 32'(h_meas), 32'd12);
    chk("s1_v_meas", 32'(v_meas), 32'd6);
    chk("s1_err_pulses", 32'(n_lerr + n_ferr), 32'd0);

    // Coordinate-tagged pixels
    do_reset();
    clear_obs();
    send_frame(VT, -1, 0, -1, 1);
    chk("s2_valid_count_f1", 32'(n_valid), 32'd32);
    n_valid = 0;
    send_frame(VT, -1, 0, -1, 1);
    chk("s2_valid_count_f2", 32'(n_valid), 32'd32);
    chk("s2_last_x", 32'(rx_x), 32'd7);
    chk("s2_last_y", 32'(rx_y), 32'd3);
    chk("s2_last_data", 32'(rx_data), 32'h070300);

    // Long line while locked, then relock
    do_reset();
    repeat (2) send_frame(VT, -1, 0, -1, 0);
    chk("s3_locked_before", 32'(locked), 32'd1);
    clear_obs();
    send_frame(VT, 3, 13, -1, 0);
    chk("s3_line_err_count", 32'(n_lerr), 32'd1);
    chk("s3_h_meas_at_err", 32'(cap_hmeas), 32'd13);
    chk("s3_locked_at_err", 32'(cap_locked), 32'd0);
    send_frame(VT, -1, 0, -1, 0);
    chk("s3_locked_in_sync", 32'(locked), 32'd0);
    send_frame(VT, -1, 0, -1, 0);
    chk("s3_relocked", 32'(locked), 32'd1);
    chk("s3_frame_err_count", 32'(n_ferr), 32'd0);

    // Seven-line frame judged while in sync
    do_reset();
    clear_obs();
    send_frame(VT + 1, -1, 0, -1, 0);
    send_frame(VT, -1, 0, -1, 0);
    chk("s4_frame_err_count", 32'(n_ferr), 32'd1);
    chk("s4_v_meas_at_err", 32'(cap_vmeas), 32'd7);
    chk("s4_no_lock", 32'(locked), 32'd0);
    send_frame(VT, -1, 0, -1, 0);
    chk("s4_locked_after_clean", 32'(locked), 32'd1);

    // Short active width while locked
    clear_obs();
    send_frame(VT, 3, HT, 7, 0);
    chk("s5_line_err_count", 32'(n_lerr), 32'd1);
    chk("s5_h_meas_at_err", 32'(cap_hmeas), 32'd12);
    chk("s5_locked_at_err", 32'(cap_locked), 32'd0);

    // Counter saturation, then asynchronous reset mid-line
    do_reset();
    repeat (2) send_frame(VT, -1, 0, -1, 0);
    clear_obs();
    send_line(1102, 0, 1'b1, 0, 0);
    send_line(HT, 0, 1'b1, 0, 0);
    chk("s6_line_err_count", 32'(n_lerr), 32'd1);
    chk("s6_h_meas_sat", 32'(cap_hmeas), 32'd1023);
    send_line(5, 0, 1'b1, 0, 0);
    do_reset();
    chk("s6_reset_locked", 32'(locked), 32'd0);

    // Randomised frames with junk on the bus between strobes
    clear_obs();
    junk = 1'b1;
    repeat (20) send_rand_frame();
    strobe(1'b0, 1'b0, 1'b0, 24'h0);
    junk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
